// File: rtl/pla_sweep_pkg.sv
// Shared types and constants for the PLA exhaustive-sweep sequencer.
// Contents: FSM state enum, default sweep width, last-vector value, counter-width helper.
package pla_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        HOLD,
        DONE
    } state_t;

    localparam int PLA_N_IN = 12;

    localparam logic [PLA_N_IN-1:0] LAST_VEC = {PLA_N_IN{1'b1}};

    // Counters must hold 2^n, one bit more than the vector width.
    function automatic int cnt_w(input int n);
        return n + 1;
    endfunction

endpackage

// File: rtl/pla_mm_reg.sv
// Single-entry valid/ready output register holding one failing vector.
// Ports: clk, rst_n, load/vin (capture), clear (drop valid), ready, valid/vec (output).
module pla_mm_reg #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] vin,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] vec
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            vec   <= '0;
        end else begin
            if (clear)
                valid <= 1'b0;
            else if (load)
                valid <= 1'b1;
            else if (valid && ready)
                valid <= 1'b0;
            if (load)
                vec <= vin;
        end
    end

endmodule

// File: rtl/pla_sweep_ctrl.sv
// Exhaustive equivalence sweep of two single-output combinational netlists.
// Ports: start/stop_on_fail/abort control, x_vec drive, y_ref/y_dut compare,
// mm_* failing-vector stream, busy/done/aborted/pass status, onset/mismatch counts.
module pla_sweep_ctrl
    import pla_sweep_pkg::*;
#(
    parameter int N_IN  = PLA_N_IN,
    parameter int CNT_W = cnt_w(N_IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop_on_fail,
    input  logic             abort,
    output logic [N_IN-1:0]  x_vec,
    input  logic             y_ref,
    input  logic             y_dut,
    output logic             mm_valid,
    input  logic             mm_ready,
    output logic [N_IN-1:0]  mm_vec,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             pass,
    output logic [CNT_W-1:0] onset_cnt,
    output logic [CNT_W-1:0] mism_cnt
);

    localparam logic [N_IN-1:0] LAST = {N_IN{1'b1}};

    state_t state, state_n;
    logic   sof;
    logic   clr, cnt_en, mis, adv, ld_mm, clr_mm, kill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        clr     = 1'b0;
        cnt_en  = 1'b0;
        mis     = 1'b0;
        adv     = 1'b0;
        ld_mm   = 1'b0;
        clr_mm  = 1'b0;
        kill    = 1'b0;
        // abort outranks every transition, including a pending transfer
        if (abort && state != IDLE) begin
            state_n = IDLE;
            clr_mm  = 1'b1;
            kill    = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        clr     = 1'b1;
                        state_n = SWEEP;
                    end
                end
                SWEEP: begin
                    cnt_en = 1'b1;
                    if (y_ref != y_dut) begin
                        mis     = 1'b1;
                        ld_mm   = 1'b1;
                        state_n = HOLD;
                    end else if (x_vec == LAST) begin
                        state_n = DONE;
                    end else begin
                        adv = 1'b1;
                    end
                end
                HOLD: begin
                    if (mm_ready) begin
                        if (sof || x_vec == LAST) begin
                            state_n = DONE;
                        end else begin
                            adv     = 1'b1;
                            state_n = SWEEP;
                        end
                    end
                end
                DONE: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_vec     <= '0;
            onset_cnt <= '0;
            mism_cnt  <= '0;
            pass      <= 1'b0;
            aborted   <= 1'b0;
            sof       <= 1'b0;
        end else begin
            if (clr) begin
                x_vec     <= '0;
                onset_cnt <= '0;
                mism_cnt  <= '0;
                pass      <= 1'b0;
                aborted   <= 1'b0;
                sof       <= stop_on_fail;
            end
            if (kill)
                aborted <= 1'b1;
            if (cnt_en)
                onset_cnt <= onset_cnt + CNT_W'(y_ref);
            if (mis)
                mism_cnt <= mism_cnt + CNT_W'(1);
            if (adv)
                x_vec <= x_vec + N_IN'(1);
            // mism_cnt is final on every path into DONE
            if (state_n == DONE && state != DONE)
                pass <= (mism_cnt == '0);
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    pla_mm_reg #(.W(N_IN)) u_mm (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ld_mm),
        .clear (clr_mm),
        .vin   (x_vec),
        .ready (mm_ready),
        .valid (mm_valid),
        .vec   (mm_vec)
    );

endmodule

// File: tb/tb_pla_sweep_ctrl.sv
// Directed self-checking bench for pla_sweep_ctrl.
// Netlist pair modelled combinationally; mode selects the injected difference.
module tb_pla_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop_on_fail;
    logic        abort;
    logic [11:0] x_vec;
    logic        y_ref;
    logic        y_dut;
    logic        mm_valid;
    logic        mm_ready;
    logic [11:0] mm_vec;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        pass;
    logic [12:0] onset_cnt;
    logic [12:0] mism_cnt;

    int checks = 0;
    int failures = 0;
    int mode = 0;

    always #5 clk = ~clk;

    assign y_ref = x_vec[0] & x_vec[1];
    assign y_dut = (mode == 0) ? y_ref :
                   (mode == 1) ? (y_ref ^ (x_vec == 12'hA5C)) : ~y_ref;

    pla_sweep_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop_on_fail (stop_on_fail),
        .abort        (abort),
        .x_vec        (x_vec),
        .y_ref        (y_ref),
        .y_dut        (y_dut),
        .mm_valid     (mm_valid),
        .mm_ready     (mm_ready),
        .mm_vec       (mm_vec),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .pass         (pass),
        .onset_cnt    (onset_cnt),
        .mism_cnt     (mism_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic sof);
        stop_on_fail = sof;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Runs until done; n = edges after the start edge at which done shows.
    task automatic run(input int rdly, output int n, output int xf,
                       output logic [11:0] lastmm, output int unstable);
        int w;
        logic [11:0] hv, hx;
        logic [12:0] ho, hm;
        w = 0; n = 0; xf = 0; lastmm = '0; unstable = 0;
        hv = '0; hx = '0; ho = '0; hm = '0;
        mm_ready = (rdly == 0);
        while (n < 10000) begin
            tick();
            n++;
            if (done) break;
            if (mm_valid) begin
                if (w == 0) begin
                    hv = mm_vec; hx = x_vec; ho = onset_cnt; hm = mism_cnt;
                end else if (mm_vec !== hv || x_vec !== hx ||
                             onset_cnt !== ho || mism_cnt !== hm) begin
                    unstable++;
                end
                mm_ready = (w >= rdly);
                if (mm_ready) begin
                    xf++;
                    lastmm = mm_vec;
                    w = 0;
                end else begin
                    w++;
                end
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; stop_on_fail = 1'b0;
        abort = 1'b0; mm_ready = 1'b0;
        #1;
        checks++;
        if ({busy, done, mm_valid, aborted, pass} !== 5'b0 ||
            x_vec !== 12'd0 || onset_cnt !== 13'd0 || mism_cnt !== 13'd0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b mmv=%b ab=%b pass=%b x=%h on=%0d mm=%0d, want all 0",
                     busy, done, mm_valid, aborted, pass, x_vec, onset_cnt, mism_cnt);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_equal;
        int n, xf, us;
        logic [11:0] lm;
        mode = 0;
        do_start(1'b0);
        run(0, n, xf, lm, us);
        checks++;
        if (n !== 4096) begin failures++; $display("FAIL eq_done_time: got %0d want 4096", n); end
        checks++;
        if (xf !== 0) begin failures++; $display("FAIL eq_reports: got %0d want 0", xf); end
        checks++;
        if (onset_cnt !== 13'd1024) begin failures++; $display("FAIL eq_onset: got %0d want 1024", onset_cnt); end
        checks++;
        if (mism_cnt !== 13'd0) begin failures++; $display("FAIL eq_mism: got %0d want 0", mism_cnt); end
        checks++;
        if (pass !== 1'b1) begin failures++; $display("FAIL eq_pass: got %b want 1", pass); end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || pass !== 1'b1) begin
            failures++;
            $display("FAIL eq_after: done=%b busy=%b pass=%b want 0 0 1", done, busy, pass);
        end
    endtask

    task automatic test_single_diff(input int rdly, input int want_n);
        int n, xf, us;
        logic [11:0] lm;
        mode = 1;
        do_start(1'b0);
        run(rdly, n, xf, lm, us);
        checks++;
        if (n !== want_n) begin failures++; $display("FAIL diff_done_time(rdly=%0d): got %0d want %0d", rdly, n, want_n); end
        checks++;
        if (xf !== 1 || lm !== 12'hA5C) begin
            failures++;
            $display("FAIL diff_report(rdly=%0d): xfers=%0d vec=%h want 1 a5c", rdly, xf, lm);
        end
        checks++;
        if (us !== 0) begin failures++; $display("FAIL diff_hold_stable(rdly=%0d): %0d changes want 0", rdly, us); end
        checks++;
        if (onset_cnt !== 13'd1024 || mism_cnt !== 13'd1 || pass !== 1'b0) begin
            failures++;
            $display("FAIL diff_counts(rdly=%0d): on=%0d mm=%0d pass=%b want 1024 1 0", rdly, onset_cnt, mism_cnt, pass);
        end
        tick();
    endtask

    task automatic test_stop_on_fail;
        int n, xf, us;
        logic [11:0] lm;
        mode = 2;
        do_start(1'b1);
        run(0, n, xf, lm, us);
        checks++;
        if (n !== 2 || xf !== 1 || lm !== 12'h000) begin
            failures++;
            $display("FAIL sof_report: n=%0d xfers=%0d vec=%h want 2 1 000", n, xf, lm);
        end
        checks++;
        if (mism_cnt !== 13'd1 || onset_cnt !== 13'd0 || pass !== 1'b0) begin
            failures++;
            $display("FAIL sof_counts: mm=%0d on=%0d pass=%b want 1 0 0", mism_cnt, onset_cnt, pass);
        end
        tick();
    endtask

    task automatic test_abort;
        int k;
        mode = 0;
        mm_ready = 1'b1;
        do_start(1'b0);
        k = 0;
        while (x_vec != 12'd100 && k < 500) begin tick(); k++; end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || aborted !== 1'b1 || done !== 1'b0 || mm_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_sweep: busy=%b ab=%b done=%b mmv=%b want 0 1 0 0", busy, aborted, done, mm_valid);
        end
        checks++;
        if (onset_cnt !== 13'd25 || x_vec !== 12'd100) begin
            failures++;
            $display("FAIL abort_partial: on=%0d x=%0d want 25 100", onset_cnt, x_vec);
        end
        mode = 1;
        mm_ready = 1'b0;
        do_start(1'b0);
        k = 0;
        while (!mm_valid && k < 5000) begin tick(); k++; end
        abort = 1'b1;
        mm_ready = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || aborted !== 1'b1 || mm_valid !== 1'b0 || mism_cnt !== 13'd1) begin
            failures++;
            $display("FAIL abort_hold: busy=%b ab=%b mmv=%b mm=%0d want 0 1 0 1", busy, aborted, mm_valid, mism_cnt);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL abort_no_done: done=%b want 0", done); end
        do_start(1'b0);
        checks++;
        if (aborted !== 1'b0 || busy !== 1'b1 || x_vec !== 12'd0 || mism_cnt !== 13'd0) begin
            failures++;
            $display("FAIL abort_restart: ab=%b busy=%b x=%h mm=%0d want 0 1 000 0", aborted, busy, x_vec, mism_cnt);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_async_reset;
        int n, xf, us;
        logic [11:0] lm;
        mode = 0;
        do_start(1'b0);
        repeat (50) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, mm_valid, aborted, pass} !== 5'b0 ||
            x_vec !== 12'd0 || onset_cnt !== 13'd0 || mism_cnt !== 13'd0) begin
            failures++;
            $display("FAIL async_reset: busy=%b done=%b mmv=%b ab=%b pass=%b x=%h on=%0d mm=%0d want all 0",
                     busy, done, mm_valid, aborted, pass, x_vec, onset_cnt, mism_cnt);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL async_idle: busy=%b want 0", busy); end
        do_start(1'b0);
        checks++;
        if (x_vec !== 12'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL async_restart: x=%h busy=%b want 000 1", x_vec, busy);
        end
        run(0, n, xf, lm, us);
        checks++;
        if (n !== 4096 || onset_cnt !== 13'd1024 || pass !== 1'b1) begin
            failures++;
            $display("FAIL async_resweep: n=%0d on=%0d pass=%b want 4096 1024 1", n, onset_cnt, pass);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_equal();
        test_single_diff(0, 4097);
        test_single_diff(10, 4107);
        test_stop_on_fail();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pla_sweep_ctrl.md
Name: pla_sweep_ctrl

Overview:
- Sequencer for exhaustive equivalence checking of a single-output combinational PLA benchmark against its optimized netlist. Examples: the 12-input br2-class functions, original vs mockturtle-optimized.
- Drives one shared N_IN-bit input vector to both instances, one vector per cycle, and compares their outputs.
- Counts onset size and mismatches. Streams each failing vector out over a valid/ready port.
- Sits in the benchmark harness between the testbench/host and the two combinational netlists.

Parameters:
- N_IN, 12: input vector width. The sweep covers 0 .. 2^N_IN-1.
- CNT_W, N_IN+1: width of the onset and mismatch counters. Must hold 2^N_IN.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a sweep; honoured only in IDLE
- stop_on_fail  input  1  sampled with start; 1 = end the sweep after the first mismatch report
- abort  input  1  synchronous cancel; returns to IDLE
- x_vec  output  N_IN  registered vector driven to both netlists (x0 = bit 0)
- y_ref  input  1  output of the original netlist for x_vec
- y_dut  input  1  output of the optimized netlist for x_vec
- mm_valid  output  1  mismatch report valid
- mm_ready  input  1  consumer accepts the report
- mm_vec  output  N_IN  failing vector
- busy  output  1  state is not IDLE
- done  output  1  one-cycle pulse when a sweep completes normally
- aborted  output  1  sticky; set by abort, cleared by start
- pass  output  1  valid after done; mism_cnt == 0
- onset_cnt  output  CNT_W  number of swept vectors with y_ref = 1
- mism_cnt  output  CNT_W  number of vectors with y_ref != y_dut

Behaviour:
- Reset: rst_n = 0 asynchronously forces state to IDLE and every output and register to 0. This applies at any point, including mid-sweep and mid-handshake.
- States: IDLE, SWEEP, HOLD, DONE.
- IDLE:
  - start = 1: clear onset_cnt, mism_cnt, pass, aborted and x_vec; latch stop_on_fail; go to SWEEP.
  - start outside IDLE is ignored.
- SWEEP (one cycle per vector v = x_vec):
  - y_ref and y_dut are sampled at the clock edge ending the cycle in which x_vec = v. The netlists are combinational, so the compare latency is zero.
  - onset_cnt += y_ref.
  - Mismatch: mism_cnt += 1, mm_vec <= v, mm_valid <= 1, go to HOLD; x_vec does not advance.
  - No mismatch, v < 2^N_IN-1: x_vec <= v+1.
  - No mismatch, v = 2^N_IN-1: go to DONE.
- HOLD:
  - Counters are frozen and x_vec holds v. Each vector is counted exactly once.
  - mm_valid and mm_vec stay stable until mm_ready = 1 (standard valid/ready). Backpressure is unbounded.
  - On the transfer edge, mm_valid <= 0, then:
    - stop_on_fail latched, or v = 2^N_IN-1: go to DONE.
    - otherwise: x_vec <= v+1, go to SWEEP.
- DONE: done = 1 for exactly one cycle, pass = (mism_cnt == 0), then IDLE. Counters, pass and mm_vec hold until the next start.
- abort = 1 in SWEEP, HOLD or DONE:
  - next state IDLE; mm_valid <= 0, even mid-handshake with no transfer; aborted <= 1.
  - no done pulse; counters keep their partial values.
  - abort has priority over all other transitions, including a simultaneous mm_ready. abort in IDLE is ignored.
- Counter wrap: impossible by construction of CNT_W. No saturation logic is needed.
- Full-sweep timing with no mismatch: done is high in the cycle after edge 2^N_IN, counting the edge that samples start as edge 0. Each report adds 1 HOLD cycle plus any mm_ready wait cycles.

Decomposition:
- Package pla_sweep_pkg holds:
  - the state enum (IDLE, SWEEP, HOLD, DONE);
  - localparam LAST_VEC = 2^N_IN-1;
  - the counter-width helper.
- One natural sub-module, pla_mm_reg: a single-entry valid/ready output register for mm_vec, with load, clear-on-abort and async reset.

Test Plan:
1. Equal functions, y_ref = y_dut = x0 & x1, start, mm_ready = 1 -> no mm_valid; done in the cycle after edge 4096; onset_cnt = 1024, mism_cnt = 0, pass = 1.
2. Single-point difference, y_dut = y_ref ^ (x_vec == 12'hA5C), mm_ready = 1 -> one transfer with mm_vec = 0xA5C; mism_cnt = 1; done one cycle later than scenario 1; pass = 0.
3. Same stimulus as scenario 2, mm_ready held low for 10 cycles after mm_valid rises -> x_vec stays 0xA5C, mm_vec stays stable, counters frozen; done delayed by a further 10 cycles; final counts identical to scenario 2.
4. stop_on_fail = 1, y_dut = ~y_ref -> one report with mm_vec = 0; done after the handshake; mism_cnt = 1; onset_cnt = y_ref(0).
5. abort asserted while x_vec = 100 in SWEEP, and separately in HOLD with mm_ready = 1 -> IDLE next cycle; no done; aborted = 1; mm_valid = 0; the next start clears aborted.
6. rst_n pulsed low mid-sweep, asynchronously between edges, then start issued in IDLE -> all outputs 0 immediately; after release the FSM is in IDLE and the next start sweeps from x_vec = 0.
